tpm_spi_txn_ctrl: RTL and testbench

- Byte-level sequencer for the MITM datapath on a TPM-over-SPI bus.
- Tracks each SPI chip-select frame through the TPM header, wait-state and data phases.
- Decodes direction, size and 24-bit register address.
- Follows the TPM FIFO response byte stream across frames and raises a look-ahead substitution request for a configurable window of response bytes (e.g. GetRandom payload), which the MITM byte replacer consumes.

---
 rtl/tpm_spi_txn_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_tpm_spi_txn_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tpm_spi_txn_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tpm_spi_txn_ctrl
// Description : Byte-level transaction sequencer for a TPM-over-SPI MITM
//               datapath. Follows each chip-select frame through the 4-byte
//               TPM header, the flow-control wait bytes and the data phase.
//               It decodes direction, size and register address, and tracks
//               the FIFO response byte stream across frames. It raises a
//               look-ahead substitution request for a window of response
//               bytes, which the downstream byte replacer consumes.
// Option      : TPM_RSP_LEN_TRACK_EN -- capture the big-endian response
//               length (stream bytes 2..5), wrap rsp_offset at the end of the
//               response and pulse rsp_complete.
// Ports       : sys_clk, n_rst       clock, asynchronous active-low reset
//               ss_active            chip select asserted (synchronized)
//               byte_valid           one-cycle strobe, full byte on both lines
//               mosi_byte/miso_byte  host->TPM / TPM->host byte
//               is_read, xfer_size,  decoded direction, byte count and
//               reg_addr             register address of the current frame
//               in_data              next bus byte is a data byte
//               sub_next             next data byte shall be substituted
//               rsp_offset           FIFO response bytes since last command
//               txn_done/proto_err   clean / abnormal end-of-frame pulses
//               rsp_complete         (option only) end-of-response pulse
// Revision    : 1.0 - initial release
// ============================================================================
module tpm_spi_txn_ctrl #(
   parameter logic [23:0] FIFO_ADDR    = 24'hD40024,
   parameter int          SUB_OFFSET   = 12,
   parameter int          SUB_LEN      = 8,
   parameter int          MAX_WAITS    = 16,
   parameter int          OFFSET_WIDTH = 16
) (
   input  logic                    sys_clk,
   input  logic                    n_rst,
   input  logic                    ss_active,
   input  logic                    byte_valid,
   input  logic [7:0]              mosi_byte,
   input  logic [7:0]              miso_byte,
   output logic                    is_read,
   output logic [6:0]              xfer_size,
   output logic [23:0]             reg_addr,
   output logic                    in_data,
   output logic                    sub_next,
   output logic [OFFSET_WIDTH-1:0] rsp_offset,
   output logic                    txn_done,
   output logic                    proto_err
`ifdef TPM_RSP_LEN_TRACK_EN
   ,
   output logic                    rsp_complete
`endif
);

   localparam int                WAIT_W     = $clog2(MAX_WAITS + 1);
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAITS);
   localparam logic [31:0]       SUB_LO     = 32'(SUB_OFFSET);
   localparam logic [31:0]       SUB_HI     = 32'(SUB_OFFSET + SUB_LEN);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HDR   = 3'd1,
      WAIT  = 3'd2,
      DATA  = 3'd3,
      DONE  = 3'd4,
      ABORT = 3'd5
   } state_t;

   state_t                  state, state_nxt;
   logic [1:0]              hdr_cnt, hdr_cnt_nxt;
   logic [WAIT_W-1:0]       wait_cnt, wait_cnt_nxt;
   logic [6:0]              data_cnt, data_cnt_nxt;
   logic                    ss_prev;
   logic                    is_read_nxt;
   logic [6:0]              xfer_size_nxt;
   logic [23:0]             reg_addr_nxt;
   logic                    in_data_nxt;
   logic                    sub_next_nxt;
   logic [OFFSET_WIDTH-1:0] rsp_offset_nxt;
   logic [OFFSET_WIDTH-1:0] rsp_inc;
   logic                    txn_done_nxt;
   logic                    proto_err_nxt;
   logic [31:0]             off_ext;
`ifdef TPM_RSP_LEN_TRACK_EN
   logic [31:0]             rsp_len, rsp_len_nxt;
   logic                    rsp_complete_nxt;
`else
   // Only the wait-state flag bit of MISO matters without length tracking.
   logic                    unused_miso;
   assign unused_miso = ^miso_byte[7:1];
`endif

   // -------------------------------------------------------------------------
   // State and output registers
   // -------------------------------------------------------------------------
   always_ff @(posedge sys_clk or negedge n_rst) begin
      if (!n_rst) begin
         state      <= IDLE;
         hdr_cnt    <= '0;
         wait_cnt   <= '0;
         data_cnt   <= '0;
         // Assume chip select was high before reset so a frame already in
         // flight is never decoded from its middle.
         ss_prev    <= 1'b1;
         is_read    <= 1'b0;
         xfer_size  <= '0;
         reg_addr   <= '0;
         in_data    <= 1'b0;
         sub_next   <= 1'b0;
         rsp_offset <= '0;
         txn_done   <= 1'b0;
         proto_err  <= 1'b0;
`ifdef TPM_RSP_LEN_TRACK_EN
         rsp_len      <= '0;
         rsp_complete <= 1'b0;
`endif
      end else begin
         state      <= state_nxt;
         hdr_cnt    <= hdr_cnt_nxt;
         wait_cnt   <= wait_cnt_nxt;
         data_cnt   <= data_cnt_nxt;
         ss_prev    <= ss_active;
         is_read    <= is_read_nxt;
         xfer_size  <= xfer_size_nxt;
         reg_addr   <= reg_addr_nxt;
         in_data    <= in_data_nxt;
         sub_next   <= sub_next_nxt;
         rsp_offset <= rsp_offset_nxt;
         txn_done   <= txn_done_nxt;
         proto_err  <= proto_err_nxt;
`ifdef TPM_RSP_LEN_TRACK_EN
         rsp_len      <= rsp_len_nxt;
         rsp_complete <= rsp_complete_nxt;
`endif
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and next-output logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_nxt      = state;
      hdr_cnt_nxt    = hdr_cnt;
      wait_cnt_nxt   = wait_cnt;
      data_cnt_nxt   = data_cnt;
      is_read_nxt    = is_read;
      xfer_size_nxt  = xfer_size;
      reg_addr_nxt   = reg_addr;
      rsp_offset_nxt = rsp_offset;
      rsp_inc        = rsp_offset;
      txn_done_nxt   = 1'b0;
      proto_err_nxt  = 1'b0;
`ifdef TPM_RSP_LEN_TRACK_EN
      rsp_len_nxt      = rsp_len;
      rsp_complete_nxt = 1'b0;
`endif

      case (state)
         IDLE: begin
            // Only a fresh rising edge of chip select opens a frame.
            if (ss_active && !ss_prev) begin
               state_nxt    = HDR;
               hdr_cnt_nxt  = '0;
               wait_cnt_nxt = '0;
               data_cnt_nxt = '0;
            end
         end

         HDR: begin
            if (byte_valid) begin
               if (hdr_cnt == 2'd0) begin
                  is_read_nxt   = mosi_byte[7];
                  xfer_size_nxt = mosi_byte[6:0] + 7'd1;
               end else begin
                  reg_addr_nxt = {reg_addr[15:0], mosi_byte};
               end
               // TPM flags "ready" in MISO bit 0 of the last header byte.
               if (hdr_cnt == 2'd3) begin
                  state_nxt = miso_byte[0] ? DATA : WAIT;
               end
               hdr_cnt_nxt = hdr_cnt + 2'd1;
            end
         end

         WAIT: begin
            if (byte_valid) begin
               if (miso_byte[0]) begin
                  state_nxt = DATA;
               end else begin
                  wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                  if (wait_cnt_nxt == WAIT_LIMIT) begin
                     proto_err_nxt = 1'b1;
                     state_nxt     = ABORT;
                  end
               end
            end
         end

         DATA: begin
            if (byte_valid) begin
               data_cnt_nxt = data_cnt + 7'd1;
               if (data_cnt_nxt == xfer_size) begin
                  state_nxt = DONE;
               end
               if (reg_addr == FIFO_ADDR) begin
                  if (is_read) begin
`ifdef TPM_RSP_LEN_TRACK_EN
                     if ((rsp_offset >= OFFSET_WIDTH'(2)) &&
                         (rsp_offset <= OFFSET_WIDTH'(5))) begin
                        rsp_len_nxt = {rsp_len[23:0], miso_byte};
                     end
`endif
                     if (rsp_offset != '1) begin
                        rsp_inc = rsp_offset + OFFSET_WIDTH'(1);
`ifdef TPM_RSP_LEN_TRACK_EN
                        // A response shorter than its own 10-byte header is
                        // not a valid length and never wraps the offset.
                        if ((rsp_len >= 32'd10) && (32'(rsp_inc) == rsp_len)) begin
                           rsp_inc          = '0;
                           rsp_complete_nxt = 1'b1;
                        end
`endif
                        rsp_offset_nxt = rsp_inc;
                     end
                  end else if (data_cnt == 7'd0) begin
                     // First byte written to the FIFO starts a new command.
                     rsp_offset_nxt = '0;
`ifdef TPM_RSP_LEN_TRACK_EN
                     rsp_len_nxt    = '0;
`endif
                  end
               end
            end
         end

         default: ;
      endcase

      // End of frame is judged after the byte of the same cycle is applied.
      if ((state != IDLE) && !ss_active) begin
         if (state_nxt == DONE) begin
            txn_done_nxt = 1'b1;
         end else if (state_nxt inside {HDR, WAIT, DATA}) begin
            proto_err_nxt = 1'b1;
         end
         state_nxt = IDLE;
      end

      in_data_nxt  = (state_nxt == DATA);
      off_ext      = 32'(rsp_offset_nxt);
      sub_next_nxt = in_data_nxt && is_read_nxt && (reg_addr_nxt == FIFO_ADDR) &&
                     (off_ext >= SUB_LO) && (off_ext < SUB_HI);
   end

endmodule
`default_nettype wire

// File: tb/tb_tpm_spi_txn_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_tpm_spi_txn_ctrl
// Description : Directed self-checking bench for tpm_spi_txn_ctrl: reset
//               values, GetRandom command/response streams in several frame
//               sizes, wait-limit abort, early chip-select release, non-FIFO
//               access, same-cycle byte/end and reset in mid-frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tpm_spi_txn_ctrl;

   localparam logic [23:0] FIFO  = 24'hD40024;
   localparam logic [23:0] OTHER = 24'hD40000;

   logic        sys_clk    = 1'b0;
   logic        n_rst      = 1'b0;
   logic        ss_active  = 1'b0;
   logic        byte_valid = 1'b0;
   logic [7:0]  mosi_byte  = 8'h00;
   logic [7:0]  miso_byte  = 8'h00;
   logic        is_read;
   logic [6:0]  xfer_size;
   logic [23:0] reg_addr;
   logic        in_data;
   logic        sub_next;
   logic [15:0] rsp_offset;
   logic        txn_done;
   logic        proto_err;
`ifdef TPM_RSP_LEN_TRACK_EN
   logic        rsp_complete;
   localparam logic [15:0] OFF_AFTER_RSP = 16'd0;
`else
   localparam logic [15:0] OFF_AFTER_RSP = 16'd20;
`endif

   int errors   = 0;
   int checks   = 0;
   int done_cnt = 0;
   int perr_cnt = 0;
   int cpl_cnt  = 0;
   logic [15:0] exp_off = 16'd0;

   logic [7:0] cmd [12];
   logic [7:0] rsp [20];

   tpm_spi_txn_ctrl dut (
      .sys_clk    (sys_clk),
      .n_rst      (n_rst),
      .ss_active  (ss_active),
      .byte_valid (byte_valid),
      .mosi_byte  (mosi_byte),
      .miso_byte  (miso_byte),
      .is_read    (is_read),
      .xfer_size  (xfer_size),
      .reg_addr   (reg_addr),
      .in_data    (in_data),
      .sub_next   (sub_next),
      .rsp_offset (rsp_offset),
      .txn_done   (txn_done),
      .proto_err  (proto_err)
`ifdef TPM_RSP_LEN_TRACK_EN
      ,
      .rsp_complete (rsp_complete)
`endif
   );

   always #5 sys_clk = ~sys_clk;

   always @(negedge sys_clk) begin
      if (txn_done)  done_cnt++;
      if (proto_err) perr_cnt++;
`ifdef TPM_RSP_LEN_TRACK_EN
      if (rsp_complete) cpl_cnt++;
`endif
   end

   task automatic send_byte(input logic [7:0] mo, input logic [7:0] mi);
      @(negedge sys_clk);
      byte_valid = 1'b1;
      mosi_byte  = mo;
      miso_byte  = mi;
      @(negedge sys_clk);
      byte_valid = 1'b0;
   endtask

   task automatic send_header(input bit rd, input int size, input logic [23:0] addr,
                              input logic [7:0] last_miso);
      send_byte({rd, 7'(size - 1)}, 8'h00);
      send_byte(addr[23:16], 8'h00);
      send_byte(addr[15:8], 8'h00);
      send_byte(addr[7:0], last_miso);
   endtask

   // Streams `total` FIFO bytes in frames of up to `fsz` bytes.
   task automatic xfer_stream(input bit rd, input int total, input int fsz);
      int idx;
      int n;
      int w;
      int d0;
      int p0;
      int frames;
      bit exp_sub;
      idx = 0; frames = 0;
      d0 = done_cnt; p0 = perr_cnt;
      while (idx < total) begin
         n = (total - idx < fsz) ? total - idx : fsz;
         w = int'($urandom_range(0, 2));
         @(negedge sys_clk);
         ss_active = 1'b1;
         send_header(rd, n, FIFO, (w == 0) ? 8'h01 : 8'h00);
         for (int k = 0; k < w; k++) send_byte(8'h00, (k == w - 1) ? 8'h01 : 8'h00);
         checks++;
         if (in_data !== 1'b1 || is_read !== rd || xfer_size !== 7'(n) || reg_addr !== FIFO) begin
            errors++;
            $display("FAIL hdr_decode: in_data=%0b is_read=%0b size=%0d addr=%h, want 1 %0b %0d %h",
                     in_data, is_read, xfer_size, reg_addr, rd, n, FIFO);
         end
         for (int j = 0; j < n; j++) begin
            exp_sub = rd && (idx >= 12) && (idx < 20);
            checks++;
            if (sub_next !== exp_sub) begin
               errors++;
               $display("FAIL sub_next at stream byte %0d (rd=%0b): got %0b want %0b",
                        idx, rd, sub_next, exp_sub);
            end
            send_byte(rd ? 8'h00 : cmd[idx], rd ? rsp[idx] : 8'h00);
            idx++;
         end
         @(negedge sys_clk);
         ss_active = 1'b0;
         @(negedge sys_clk);
         frames++;
         checks++;
         if (txn_done !== 1'b1 || in_data !== 1'b0) begin
            errors++;
            $display("FAIL frame_end: txn_done=%0b in_data=%0b, want 1 0", txn_done, in_data);
         end
         if (!rd && frames == 1) begin
            checks++;
            if (rsp_offset !== 16'd0) begin
               errors++;
               $display("FAIL offset_clear: rsp_offset=%0d want 0", rsp_offset);
            end
         end
      end
      @(negedge sys_clk);
      checks++;
      if (done_cnt - d0 != frames || perr_cnt != p0) begin
         errors++;
         $display("FAIL pulse_count: txn_done=%0d proto_err=%0d, want %0d 0",
                  done_cnt - d0, perr_cnt - p0, frames);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge sys_clk);
      checks++;
      if (is_read !== 0 || xfer_size !== 0 || reg_addr !== 0 || in_data !== 0 ||
          sub_next !== 0 || rsp_offset !== 0 || txn_done !== 0 || proto_err !== 0) begin
         errors++;
         $display("FAIL reset_values: rd=%0b sz=%0d addr=%h in=%0b sub=%0b off=%0d done=%0b err=%0b, want all 0",
                  is_read, xfer_size, reg_addr, in_data, sub_next, rsp_offset, txn_done, proto_err);
      end
      n_rst = 1'b1;
      repeat (2) @(negedge sys_clk);
   endtask

   task automatic test_getrandom(input int fsz);
      int c0;
      c0 = cpl_cnt;
      xfer_stream(1'b0, 12, fsz);
      xfer_stream(1'b1, 20, fsz);
      exp_off = OFF_AFTER_RSP;
      checks++;
      if (rsp_offset !== exp_off) begin
         errors++;
         $display("FAIL rsp_offset_end (fsz=%0d): got %0d want %0d", fsz, rsp_offset, exp_off);
      end
`ifdef TPM_RSP_LEN_TRACK_EN
      checks++;
      if (cpl_cnt - c0 != 1) begin
         errors++;
         $display("FAIL rsp_complete_count: got %0d want 1", cpl_cnt - c0);
      end
`else
      c0 = c0 + 0;
`endif
   endtask

   task automatic test_wait_abort();
      int d0;
      d0 = done_cnt;
      @(negedge sys_clk);
      ss_active = 1'b1;
      send_byte(8'h83, 8'h00);
      send_byte(8'h00, 8'h00);
      send_byte(8'h0F, 8'h00);
      send_byte(8'h00, 8'h00);
      checks++;
      if (is_read !== 1'b1 || xfer_size !== 7'd4 || reg_addr !== 24'h000F00 || in_data !== 1'b0) begin
         errors++;
         $display("FAIL wait_hdr: rd=%0b sz=%0d addr=%h in=%0b, want 1 4 000f00 0",
                  is_read, xfer_size, reg_addr, in_data);
      end
      for (int k = 1; k <= 16; k++) begin
         send_byte(8'h00, 8'h00);
         if (k == 15) begin
            checks++;
            if (proto_err !== 1'b0) begin
               errors++;
               $display("FAIL wait_15: proto_err=%0b want 0", proto_err);
            end
         end
      end
      checks++;
      if (proto_err !== 1'b1 || in_data !== 1'b0) begin
         errors++;
         $display("FAIL wait_limit: proto_err=%0b in_data=%0b, want 1 0", proto_err, in_data);
      end
      @(negedge sys_clk);
      ss_active = 1'b0;
      @(negedge sys_clk);
      @(negedge sys_clk);
      checks++;
      if (done_cnt != d0 || txn_done !== 1'b0 || proto_err !== 1'b0) begin
         errors++;
         $display("FAIL abort_end: txn_done pulses=%0d err=%0b, want 0 0", done_cnt - d0, proto_err);
      end
   endtask

   task automatic test_early_end();
      @(negedge sys_clk);
      ss_active = 1'b1;
      send_header(1'b1, 4, OTHER, 8'h01);
      send_byte(8'h00, 8'h11);
      send_byte(8'h00, 8'h22);
      @(negedge sys_clk);
      ss_active = 1'b0;
      @(negedge sys_clk);
      checks++;
      if (proto_err !== 1'b1 || txn_done !== 1'b0 || in_data !== 1'b0) begin
         errors++;
         $display("FAIL early_end: proto_err=%0b txn_done=%0b in_data=%0b, want 1 0 0",
                  proto_err, txn_done, in_data);
      end
   endtask

   task automatic test_non_fifo();
      @(negedge sys_clk);
      ss_active = 1'b1;
      send_header(1'b1, 4, OTHER, 8'h00);
      send_byte(8'h00, 8'h01);
      checks++;
      if (in_data !== 1'b1 || is_read !== 1'b1 || xfer_size !== 7'd4 || reg_addr !== OTHER) begin
         errors++;
         $display("FAIL nonfifo_hdr: in=%0b rd=%0b sz=%0d addr=%h, want 1 1 4 %h",
                  in_data, is_read, xfer_size, reg_addr, OTHER);
      end
      for (int j = 0; j < 4; j++) begin
         checks++;
         if (sub_next !== 1'b0) begin
            errors++;
            $display("FAIL nonfifo_sub byte %0d: got %0b want 0", j, sub_next);
         end
         send_byte(8'h00, 8'h5A);
      end
      @(negedge sys_clk);
      ss_active = 1'b0;
      @(negedge sys_clk);
      checks++;
      if (txn_done !== 1'b1 || rsp_offset !== exp_off) begin
         errors++;
         $display("FAIL nonfifo_end: txn_done=%0b rsp_offset=%0d, want 1 %0d",
                  txn_done, rsp_offset, exp_off);
      end
   endtask

   task automatic test_same_cycle_end();
      @(negedge sys_clk);
      ss_active = 1'b1;
      send_header(1'b0, 2, OTHER, 8'h01);
      send_byte(8'hA5, 8'h00);
      @(negedge sys_clk);
      byte_valid = 1'b1;
      mosi_byte  = 8'h5A;
      ss_active  = 1'b0;
      @(negedge sys_clk);
      byte_valid = 1'b0;
      checks++;
      if (txn_done !== 1'b1 || proto_err !== 1'b0) begin
         errors++;
         $display("FAIL same_cycle_end: txn_done=%0b proto_err=%0b, want 1 0", txn_done, proto_err);
      end
   endtask

   task automatic test_reset_mid_frame();
      @(negedge sys_clk);
      ss_active = 1'b1;
      send_header(1'b1, 4, FIFO, 8'h01);
      send_byte(8'h00, 8'h80);
      #2 n_rst = 1'b0;
      #1;
      checks++;
      if (is_read !== 0 || xfer_size !== 0 || reg_addr !== 0 || in_data !== 0 ||
          sub_next !== 0 || rsp_offset !== 0 || txn_done !== 0 || proto_err !== 0) begin
         errors++;
         $display("FAIL async_reset: rd=%0b sz=%0d addr=%h in=%0b off=%0d, want all 0",
                  is_read, xfer_size, reg_addr, in_data, rsp_offset);
      end
      @(negedge sys_clk);
      n_rst = 1'b1;
      // Chip select stays high through reset: these bytes must not decode.
      send_header(1'b1, 4, FIFO, 8'h01);
      checks++;
      if (in_data !== 1'b0 || xfer_size !== 7'd0 || reg_addr !== 24'd0) begin
         errors++;
         $display("FAIL held_ss_decode: in=%0b sz=%0d addr=%h, want 0 0 000000",
                  in_data, xfer_size, reg_addr);
      end
      @(negedge sys_clk);
      ss_active = 1'b0;
      @(negedge sys_clk);
      checks++;
      if (txn_done !== 1'b0 || proto_err !== 1'b0) begin
         errors++;
         $display("FAIL held_ss_end: txn_done=%0b proto_err=%0b, want 0 0", txn_done, proto_err);
      end
      exp_off = 16'd0;
      test_non_fifo();
   endtask

   initial begin
      cmd = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h01, 8'h7B, 8'h00, 8'h08};
      rsp = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h14, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h00, 8'h08, 8'h4A, 8'h3B, 8'h1C, 8'h21, 8'h01, 8'hA7, 8'hCC, 8'h09};
      test_reset();
      test_getrandom(1);
      test_getrandom(4);
      test_getrandom(5);
      test_wait_abort();
      test_early_end();
      test_non_fifo();
      test_same_cycle_end();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
